dmem_ctrl: RTL
==============

# dmem_ctrl

Sequencing controller and two-way arbiter for the single-port 32-word data RAM behind the MEM stage. It accepts load/store requests from the EX/MEM register and from a program-loader/debug port, and drives the RAM with a fixed read latency. It stalls the pipeline until the access completes and returns read data aligned to the cycle the pipeline advances.

## Interface
Parameters:
- ADDR_W, 5, RAM word-index width (depth 2**ADDR_W)
- LAT, 2, cycles from ram_en (read) to ram_rdata valid; legal range 1..7

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- m  in  2  MEM control from EX/MEM: m[1] read, m[0] write
- address_MEM  in  32  word address (word index, not byte address)
- write_data_mem  in  32  store data
- read_data_mem  out  32  load result, valid in DONE cycle
- stall  out  1  freeze IF/ID/EX/MEM registers
- ld_req  in  1  loader request, level, held until ld_done
- ld_we  in  1  loader write (1) / read (0)
- ld_addr  in  32  loader word address
- ld_wdata  in  32  loader write data
- ld_rdata  out  32  loader read result, valid with ld_done
- ld_done  out  1  one-cycle completion pulse
- addr_err  out  1  one-cycle pulse: address above 2**ADDR_W-1
- ram_en  out  1  RAM access strobe, one cycle per access
- ram_we  out  1  RAM write enable, qualified by ram_en
- ram_addr  out  ADDR_W  RAM word index
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid LAT cycles after ram_en

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: a request is pending if m != 0 (pipeline) or ld_req (loader).
  - Single pending: grant it.
  - Both pending: round-robin; grant the requester not granted last.
  - last_grant resets to loader, so the pipeline wins the first tie.
  - Latch owner, we, addr, wdata; go to ISSUE.
- m = 2'b11 is treated as a write; read_data_mem = 0 for that access.
- ISSUE: ram_en = 1 for exactly one cycle; ram_we = latched we.
  - Write: go to DONE.
  - Read: load wait counter with LAT-1; go to WAIT (LAT = 1 goes straight to WAIT with counter 0).
- WAIT: decrement counter. At 0, capture ram_rdata into the owner's read register and go to DONE.
- DONE: pipeline owner returns read_data_mem; loader owner gets ld_done = 1 with ld_rdata. Then return to IDLE.
- IDLE never grants in the same cycle as DONE, so a pipeline request still present in DONE is not re-serviced.
- Out-of-range address (any bit ≥ ADDR_W set):
  - Go IDLE→DONE directly with no ram_en; read data = 0; addr_err pulses in DONE.
- read_data_mem and ld_rdata hold their value until the next capture of that owner.

## Timing
- stall = (pipeline request pending in IDLE) | (state ∈ {ISSUE, WAIT} with owner = pipeline) | (state ∈ {ISSUE, WAIT, DONE} with owner = loader and m != 0). This is combinational from state and m; stall is 0 during rst.
- Pipeline read, request seen at cycle 0:
  - ram_en at cycle 1; capture at cycle 1+LAT; DONE at cycle 2+LAT.
  - stall high for cycles 0..1+LAT, i.e. LAT+2 cycles.
- Pipeline write: ram_en at cycle 1, DONE at cycle 2, stall for 2 cycles.
- Out-of-range: DONE at cycle 1, stall 1 cycle.
- A pipeline request arriving while the loader owns the FSM stalls until the loader's DONE ends. It is then granted in the next IDLE.
- Reset values: state IDLE, read_data_mem 0, ld_rdata 0, ld_done 0, addr_err 0, ram_en 0, ram_we 0, ram_addr 0, ram_wdata 0, last_grant = loader.
- Reset mid-access aborts it: no capture, no ld_done, ram_en low in the first cycle after reset.

## Structure
- Package dmem_ctrl_pkg: state enum (IDLE, ISSUE, WAIT, DONE), owner enum (PIPE, LOADER), default LAT.
- Sub-module rr_arb2: 2-requester round-robin arbiter with last_grant register, updated only on grant.
- Wait counter, FSM and capture registers live in dmem_ctrl.

## Test plan
- LAT=2, pipeline read with m=2'b10, address 5, RAM[5]=0xDEADBEEF → ram_en at cycle 1; stall high for cycles 0–3; read_data_mem = 0xDEADBEEF at cycle 4 with stall low.
- Pipeline write with m=2'b01, address 31, data 0x12345678 → single ram_en/ram_we pulse with ram_addr=31; stall for 2 cycles; a subsequent read of 31 returns 0x12345678.
- Pipeline and loader both request at cycle 0 after reset → pipeline served first. A second simultaneous pair → loader served first (alternation).
- Loader read in progress when the pipeline raises m=2'b10 → stall held through the loader's DONE; ld_done pulses once; pipeline access issues afterwards.
- address_MEM = 32 → no ram_en; addr_err pulse; read_data_mem = 0; stall for 1 cycle.
- rst asserted during WAIT → no capture, no ld_done, all outputs at reset values; the next request completes normally.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dmem_ctrl_pkg
// Shared types and defaults for the MEM-stage data RAM controller.
//   state_t : controller FSM states (IDLE, ISSUE, WAIT, DONE)
//   owner_t : which requester owns the current access (PIPE, LOADER).
//             The encoding doubles as the request/grant vector index in
//             rr_arb2 (PIPE = bit 0, LOADER = bit 1).
//   DEFAULT_LAT : default RAM read latency in cycles
// ---------------------------------------------------------------------------
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        PIPE   = 1'b0,
        LOADER = 1'b1
    } owner_t;

    localparam int DEFAULT_LAT = 2;

    // Width of the read-latency down-counter; covers LAT up to 7.
    localparam int CNT_W = 3;

endpackage

// File: rtl/dmem_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. Grants are combinational from req and
// the last_grant register; last_grant only moves when a grant is issued.
// On a tie the requester that was not granted last wins. last_grant resets
// to LOADER so the pipeline wins the first tie after reset.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   en       : arbitration allowed this cycle (controller idle)
//   req[1:0] : requests, indexed by owner_t (bit 0 pipeline, bit 1 loader)
//   gnt[1:0] : one-hot (or zero) grant, same indexing
// ---------------------------------------------------------------------------
module rr_arb2
    import dmem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    owner_t last_grant_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
        localparam int     OTHER = 1 - gi;
        localparam owner_t SELF  = owner_t'(gi);
        // Win when alone, or on a tie when this requester was not granted last.
        assign gnt[gi] = en & req[gi] & (~req[OTHER] | (last_grant_reg != SELF));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= LOADER;
        end else if (gnt[LOADER]) begin
            last_grant_reg <= LOADER;
        end else if (gnt[PIPE]) begin
            last_grant_reg <= PIPE;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl
// Sequencing controller and two-way arbiter for the single-port data RAM
// behind the MEM stage. Serves load/store requests from the EX/MEM register
// and from a program-loader/debug port, drives the RAM with a fixed read
// latency, stalls the pipeline until its access completes and presents the
// load result in the cycle the pipeline advances (DONE).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   m[1:0]            : pipeline control, m[1] read, m[0] write (11 = write)
//   address_MEM       : pipeline word address
//   write_data_mem    : pipeline store data
//   read_data_mem     : pipeline load result, valid in DONE, held afterwards
//   stall             : freeze IF/ID/EX/MEM registers
//   ld_req/ld_we      : loader request (level, held until ld_done), write flag
//   ld_addr/ld_wdata  : loader word address / write data
//   ld_rdata, ld_done : loader read result and one-cycle completion pulse
//   addr_err          : one-cycle pulse in DONE for an out-of-range address
//   ram_en/ram_we     : RAM access strobe (one cycle) and write enable
//   ram_addr/ram_wdata: RAM word index and write data
//   ram_rdata         : RAM read data, valid LAT cycles after ram_en
// Parameters: ADDR_W (RAM index width), LAT (read latency, 1..7)
// ---------------------------------------------------------------------------
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int LAT    = DEFAULT_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        m,
    input  logic [31:0]       address_MEM,
    input  logic [31:0]       write_data_mem,
    output logic [31:0]       read_data_mem,
    output logic              stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic [31:0]       ld_rdata,
    output logic              ld_done,
    output logic              addr_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    // Counter preload: the WAIT state lasts LAT cycles including the capture
    // cycle, so it counts LAT-1 down to 0.
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(LAT - 1);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t             state_reg,      state_next;
    owner_t             owner_reg,      owner_next;
    logic               we_reg,         we_next;
    logic [ADDR_W-1:0]  addr_reg,       addr_next;
    logic [31:0]        wdata_reg,      wdata_next;
    logic [CNT_W-1:0]   cnt_reg,        cnt_next;
    logic               oor_reg,        oor_next;
    logic [31:0]        rdata_pipe_reg, rdata_pipe_next;
    logic [31:0]        rdata_ld_reg,   rdata_ld_next;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic        pipe_req;
    logic        arb_en;
    logic [1:0]  arb_req;
    logic [1:0]  arb_gnt;
    logic        gnt_pipe;
    logic        gnt_ld;

    assign pipe_req = |m;
    // Only IDLE arbitrates; DONE always returns to IDLE first, so a pipeline
    // request still visible in DONE is never serviced twice.
    assign arb_en   = (state_reg == IDLE);
    assign arb_req  = {ld_req, pipe_req};
    assign gnt_pipe = arb_gnt[PIPE];
    assign gnt_ld   = arb_gnt[LOADER];

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req (arb_req),
        .gnt (arb_gnt)
    );

    // Request selected by the arbiter.
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_oor;

    always_comb begin
        sel_we    = ld_we;
        sel_addr  = ld_addr;
        sel_wdata = ld_wdata;
        if (gnt_pipe) begin
            // m = 2'b11 has m[0] set and is therefore handled as a write.
            sel_we    = m[0];
            sel_addr  = address_MEM;
            sel_wdata = write_data_mem;
        end
        // Any address bit at or above ADDR_W makes the access out of range.
        sel_oor = |(sel_addr >> ADDR_W);
    end

    // -----------------------------------------------------------------------
    // FSM next state and datapath updates
    // -----------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        cnt_next        = cnt_reg;
        oor_next        = oor_reg;
        rdata_pipe_next = rdata_pipe_reg;
        rdata_ld_next   = rdata_ld_reg;

        case (state_reg)
            IDLE: begin
                if (gnt_pipe || gnt_ld) begin
                    owner_next = gnt_ld ? LOADER : PIPE;
                    we_next    = sel_we;
                    addr_next  = sel_addr[ADDR_W-1:0];
                    wdata_next = sel_wdata;
                    oor_next   = sel_oor;
                    if (sel_oor) begin
                        // Rejected access: skip the RAM, report zero data.
                        state_next = DONE;
                        if (gnt_ld) begin
                            rdata_ld_next = '0;
                        end else begin
                            rdata_pipe_next = '0;
                        end
                    end else begin
                        state_next = ISSUE;
                        // Combined read+write from the pipeline returns zero.
                        if (gnt_pipe && (m == 2'b11)) begin
                            rdata_pipe_next = '0;
                        end
                    end
                end
            end

            ISSUE: begin
                if (we_reg) begin
                    state_next = DONE;
                end else begin
                    cnt_next   = WAIT_INIT;
                    state_next = WAIT;
                end
            end

            WAIT: begin
                if (cnt_reg == '0) begin
                    if (owner_reg == LOADER) begin
                        rdata_ld_next = ram_rdata;
                    end else begin
                        rdata_pipe_next = ram_rdata;
                    end
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= PIPE;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            cnt_reg        <= '0;
            oor_reg        <= 1'b0;
            rdata_pipe_reg <= '0;
            rdata_ld_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            cnt_reg        <= cnt_next;
            oor_reg        <= oor_next;
            rdata_pipe_reg <= rdata_pipe_next;
            rdata_ld_reg   <= rdata_ld_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    logic st_busy;   // ISSUE or WAIT
    logic st_done;

    assign st_busy = (state_reg == ISSUE) || (state_reg == WAIT);
    assign st_done = (state_reg == DONE);

    assign ram_en    = (state_reg == ISSUE);
    assign ram_we    = ram_en & we_reg;
    assign ram_addr  = addr_reg;
    assign ram_wdata = wdata_reg;

    assign read_data_mem = rdata_pipe_reg;
    assign ld_rdata      = rdata_ld_reg;
    assign ld_done       = st_done & (owner_reg == LOADER);
    assign addr_err      = st_done & oor_reg;

    // The pipeline is released in its own DONE cycle (data is valid there),
    // but stays frozen through a loader access including the loader's DONE,
    // since its request can only be granted in the following IDLE.
    assign stall = ~rst & (
                     (arb_en & pipe_req)
                   | (st_busy & (owner_reg == PIPE))
                   | ((st_busy | st_done) & (owner_reg == LOADER) & pipe_req));

endmodule
